rt_obi_rr_arbiter: RTL and testbench
====================================

// Module: rt_obi_rr_arbiter
// PURPOSE
//   Shares one OBI memory/peripheral port of the RT subsystem between NumReq OBI managers
//   (core data port, debug-module SBA, DMA). Round-robin arbitration with an address-phase lock.
//   Routes in-order responses back to the issuing manager through an outstanding-ID FIFO.
//   Sits between the managers and the subsystem interconnect slave port.
// PARAMETERS
//   NumReq          3   number of upstream managers (>=2)
//   AddrW           32  address width
//   DataW           32  data width; byte enables are DataW/8 bits
//   MaxOutstanding  4   response-ID FIFO depth (power of 2, >=2)
// PORTS
//   clk_i         in   1              system clock
//   rst_i         in   1              async reset, active-high
//   req_i         in   NumReq         per-manager request
//   we_i          in   NumReq         per-manager write enable
//   be_i          in   NumReq*DataW/8 per-manager byte enables (manager i at slice i)
//   addr_i        in   NumReq*AddrW   per-manager address
//   wdata_i       in   NumReq*DataW   per-manager write data
//   gnt_o         out  NumReq         per-manager grant
//   rvalid_o      out  NumReq         per-manager response valid
//   rdata_o       out  DataW          response data, broadcast to all managers
//   err_o         out  NumReq         per-manager response error
//   mem_req_o     out  1              downstream request
//   mem_we_o      out  1              downstream write enable
//   mem_be_o      out  DataW/8        downstream byte enables
//   mem_addr_o    out  AddrW          downstream address
//   mem_wdata_o   out  DataW          downstream write data
//   mem_gnt_i     in   1              downstream grant
//   mem_rvalid_i  in   1              downstream response valid (in order, >=1 cycle after gnt)
//   mem_rdata_i   in   DataW          downstream response data
//   mem_err_i     in   1              downstream response error
//   spurious_o    out  1              sticky flag: mem_rvalid_i received with no transaction outstanding
// BEHAVIOUR
// - Reset (async, rst_i=1): rr_ptr=0; lock cleared; FIFO empty (wr_ptr=rd_ptr=count=0);
//   spurious_o=0. All outputs are 0 while reset is asserted.
// - Selection (combinational): if locked, sel = lock_idx. Otherwise sel is the first i with
//   req_i[i]=1, searching rr_ptr, rr_ptr+1, ..., wrapping modulo NumReq.
// - mem_req_o = (locked | |req_i) & ~fifo_full. mem_we/be/addr/wdata are the sel slice when
//   mem_req_o=1; they are 0 otherwise.
// - gnt_o[sel] = mem_req_o & mem_gnt_i. All other bits are 0. Zero-cycle request path.
// - Lock: set to sel when mem_req_o=1 and mem_gnt_i=0. Cleared on the handshake
//   (mem_req_o & mem_gnt_i). While locked, other requests are ignored, so the downstream
//   address phase stays stable (OBI rule).
// - On handshake: push sel into the FIFO. rr_ptr <= (sel+1) mod NumReq.
//   A granted manager has the lowest priority in the next arbitration.
// - FIFO full (count == MaxOutstanding): mem_req_o=0 and no grants are issued.
//   A pop in the same cycle does not unblock; requests resume the next cycle.
//   The lock is kept while full.
// - Response: when mem_rvalid_i=1 and the FIFO is not empty: rvalid_o[head]=1,
//   err_o[head]=mem_err_i, rdata_o=mem_rdata_i (all combinational), then pop.
//   rdata_o is 0 when mem_rvalid_i=0.
// - mem_rvalid_i=1 with the FIFO empty: the response is dropped, no rvalid_o bit is set,
//   and spurious_o<=1 (sticky until reset).
// - Push and pop in the same cycle: count is unchanged and both pointers advance.
//   Pointers wrap modulo MaxOutstanding.
// - Reset mid-transaction: outstanding IDs are discarded. Any later downstream rvalid
//   counts as spurious.
// TESTING
// 1 Single manager: req_i=3'b010, mem_gnt_i=1 -> gnt_o=3'b010 in the same cycle.
//   Response 1 cycle later with rdata 0xCAFE0001 -> rvalid_o=3'b010, rdata_o=0xCAFE0001.
// 2 Round-robin: req_i=3'b111 held, mem_gnt_i=1 every cycle -> grants go 0,1,2,0,1,2 on
//   consecutive cycles.
// 3 Lock: req_i=3'b001, mem_gnt_i=0 for 3 cycles, req_i[2] rises in cycle 2 -> mem_addr_o
//   stays at manager 0's address. gnt_o=3'b001 when mem_gnt_i=1, then manager 2 is served.
// 4 Full: MaxOutstanding=4, 4 grants with no responses -> mem_req_o=0 on the 5th.
//   One rvalid -> mem_req_o=1 the following cycle.
// 5 Ordering: grants to 2,0,1, responses 0xA,0xB(err),0xC -> rvalid_o goes 3'b100 then
//   3'b001 (err_o=3'b001) then 3'b010.
// 6 Spurious and reset: rvalid with an empty FIFO -> spurious_o=1 and no rvalid_o.
//   Assert rst_i with 2 outstanding -> FIFO empty, spurious_o=0, gnt_o=0.

Source files
------------

// File: rtl/rt_obi_rr_arbiter_if.sv
// rtl/rt_obi_rr_arbiter_if.sv - manager-side and downstream OBI signals of the RT round-robin arbiter
interface rt_obi_rr_arbiter_if #(
  parameter int NumReq = 3,
  parameter int AddrW  = 32,
  parameter int DataW  = 32
);
  logic [NumReq-1:0]         req_i;
  logic [NumReq-1:0]         we_i;
  logic [NumReq*DataW/8-1:0] be_i;
  logic [NumReq*AddrW-1:0]   addr_i;
  logic [NumReq*DataW-1:0]   wdata_i;
  logic [NumReq-1:0]         gnt_o;
  logic [NumReq-1:0]         rvalid_o;
  logic [DataW-1:0]          rdata_o;
  logic [NumReq-1:0]         err_o;
  logic                      mem_req_o;
  logic                      mem_we_o;
  logic [DataW/8-1:0]        mem_be_o;
  logic [AddrW-1:0]          mem_addr_o;
  logic [DataW-1:0]          mem_wdata_o;
  logic                      mem_gnt_i;
  logic                      mem_rvalid_i;
  logic [DataW-1:0]          mem_rdata_i;
  logic                      mem_err_i;
  logic                      spurious_o;

  // master: the managers plus the downstream port around the arbiter
  modport master (
    output req_i, we_i, be_i, addr_i, wdata_i,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_err_i,
    input  gnt_o, rvalid_o, rdata_o, err_o, spurious_o,
    input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o
  );

  modport slave (
    input  req_i, we_i, be_i, addr_i, wdata_i,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_err_i,
    output gnt_o, rvalid_o, rdata_o, err_o, spurious_o,
    output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/rt_obi_rr_arbiter.sv
// rtl/rt_obi_rr_arbiter.sv - round-robin OBI arbiter with address-phase lock and in-order response routing
module rt_obi_rr_arbiter #(
  parameter int NumReq         = 3,
  parameter int AddrW          = 32,
  parameter int DataW          = 32,
  parameter int MaxOutstanding = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  rt_obi_rr_arbiter_if.slave   bus
);
  localparam int BeW  = DataW / 8;
  localparam int SelW = $clog2(NumReq);
  localparam int PtrW = $clog2(MaxOutstanding);

  logic [SelW-1:0] rr_ptr, lock_idx, sel;
  logic            locked;
  logic [SelW-1:0] fifo_q [MaxOutstanding];
  logic [PtrW-1:0] wr_ptr, rd_ptr;
  logic [PtrW:0]   count;
  logic            spurious_q;

  logic fifo_full, fifo_empty, mem_req, handshake, rsp_valid, found;
  logic [SelW-1:0]   head;
  logic [NumReq-1:0] gnt, rvalid, err;

  assign fifo_full  = (count == (PtrW+1)'(MaxOutstanding));
  assign fifo_empty = (count == '0);
  assign head       = fifo_q[rd_ptr];

  // Locked manager wins; otherwise first requester at or after rr_ptr.
  always_comb begin
    int idx;
    sel   = rr_ptr;
    found = 1'b0;
    idx   = 0;
    if (locked) begin
      sel = lock_idx;
    end else begin
      for (int k = 0; k < NumReq; k++) begin
        idx = (int'(rr_ptr) + k) % NumReq;
        if (!found && bus.req_i[SelW'(idx)]) begin
          sel   = SelW'(idx);
          found = 1'b1;
        end
      end
    end
  end

  assign mem_req   = ~rst_i & (locked | (|bus.req_i)) & ~fifo_full;
  assign handshake = mem_req & bus.mem_gnt_i;
  assign rsp_valid = ~rst_i & bus.mem_rvalid_i & ~fifo_empty;

  always_comb begin
    gnt    = '0;
    rvalid = '0;
    err    = '0;
    if (handshake) gnt[sel] = 1'b1;
    if (rsp_valid) begin
      rvalid[head] = 1'b1;
      err[head]    = bus.mem_err_i;
    end
  end

  assign bus.gnt_o       = gnt;
  assign bus.rvalid_o    = rvalid;
  assign bus.err_o       = err;
  assign bus.rdata_o     = rsp_valid ? bus.mem_rdata_i : '0;
  assign bus.mem_req_o   = mem_req;
  assign bus.mem_we_o    = mem_req ? bus.we_i[sel] : 1'b0;
  assign bus.mem_be_o    = mem_req ? bus.be_i[sel*BeW +: BeW] : '0;
  assign bus.mem_addr_o  = mem_req ? bus.addr_i[sel*AddrW +: AddrW] : '0;
  assign bus.mem_wdata_o = mem_req ? bus.wdata_i[sel*DataW +: DataW] : '0;
  assign bus.spurious_o  = spurious_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr     <= '0;
      lock_idx   <= '0;
      locked     <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      spurious_q <= 1'b0;
      for (int i = 0; i < MaxOutstanding; i++) fifo_q[i] <= '0;
    end else begin
      if (handshake) begin
        fifo_q[wr_ptr] <= sel;
        wr_ptr         <= wr_ptr + 1'b1;
        rr_ptr         <= (sel == SelW'(NumReq - 1)) ? '0 : sel + 1'b1;
        locked         <= 1'b0;
      end else if (mem_req) begin
        locked   <= 1'b1;
        lock_idx <= sel;
      end
      if (rsp_valid) rd_ptr <= rd_ptr + 1'b1;
      case ({handshake, rsp_valid})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (bus.mem_rvalid_i && fifo_empty) spurious_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_rt_obi_rr_arbiter.sv
// tb/tb_rt_obi_rr_arbiter.sv - bench for rt_obi_rr_arbiter
module tb_rt_obi_rr_arbiter;
  localparam int NumReq = 3;
  localparam int AddrW  = 32;
  localparam int DataW  = 32;
  localparam int MaxOut = 4;
  localparam int BeW    = DataW / 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rt_obi_rr_arbiter_if #(.NumReq(NumReq), .AddrW(AddrW), .DataW(DataW)) bus ();

  rt_obi_rr_arbiter #(.NumReq(NumReq), .AddrW(AddrW), .DataW(DataW), .MaxOutstanding(MaxOut)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct {
    int               mgr;
    logic [DataW-1:0] data;
    logic             err;
  } rsp_t;

  rsp_t exp_q[$];
  rsp_t pend_q[$];
  rsp_t fixed_q[$];

  int checks = 0;
  int errors = 0;

  logic [NumReq-1:0] req_v, we_v, mdl_gnt_vec;
  logic [AddrW-1:0]  addr_v  [NumReq];
  logic [DataW-1:0]  wdata_v [NumReq];
  logic [BeW-1:0]    be_v    [NumReq];
  logic              gnt_v, rv_en, spur_en;
  logic [NumReq-1:0] last_gnt;
  logic              last_memreq, last_spur;
  logic [AddrW-1:0]  last_addr;
  int                mdl_last, mdl_lock;
  logic              mdl_spur;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_model();
    exp_q.delete();
    pend_q.delete();
    fixed_q.delete();
    mdl_last    = NumReq - 1;
    mdl_lock    = -1;
    mdl_spur    = 1'b0;
    mdl_gnt_vec = '0;
  endtask

  // One bus cycle: drive at the falling edge, check mid-cycle, advance the model.
  task automatic cycle();
    logic rv, mreq, hs, pend_rsp;
    int   sel, ss;
    rsp_t r;
    for (int i = 0; i < NumReq; i++) begin
      bus.req_i[i]                   = req_v[i];
      bus.we_i[i]                    = we_v[i];
      bus.be_i[i*BeW +: BeW]         = be_v[i];
      bus.addr_i[i*AddrW +: AddrW]   = addr_v[i];
      bus.wdata_i[i*DataW +: DataW]  = wdata_v[i];
    end
    pend_rsp = (pend_q.size() > 0);
    rv = rv_en && (pend_rsp || spur_en);
    bus.mem_gnt_i    = gnt_v;
    bus.mem_rvalid_i = rv;
    if (rv && pend_rsp) begin
      bus.mem_rdata_i = pend_q[0].data;
      bus.mem_err_i   = pend_q[0].err;
    end else begin
      bus.mem_rdata_i = $urandom;
      bus.mem_err_i   = 1'($urandom_range(0, 1));
    end
    #2;
    sel = -1;
    if (mdl_lock >= 0) sel = mdl_lock;
    else
      for (int k = 0; k < NumReq; k++) begin
        int idx = (mdl_last + 1 + k) % NumReq;
        if (sel < 0 && req_v[idx]) sel = idx;
      end
    ss   = (sel < 0) ? 0 : sel;
    mreq = (sel >= 0) && (pend_q.size() < MaxOut);
    hs   = mreq && gnt_v;
    check("mem_req", 64'(bus.mem_req_o), 64'(mreq));
    check("gnt", 64'(bus.gnt_o), hs ? 64'(1) << ss : 64'(0));
    check("mem_addr", 64'(bus.mem_addr_o), mreq ? 64'(addr_v[ss]) : 64'(0));
    check("mem_wdata", 64'(bus.mem_wdata_o), mreq ? 64'(wdata_v[ss]) : 64'(0));
    check("mem_be", 64'(bus.mem_be_o), mreq ? 64'(be_v[ss]) : 64'(0));
    check("mem_we", 64'(bus.mem_we_o), mreq ? 64'(we_v[ss]) : 64'(0));
    check("rdata", 64'(bus.rdata_o), (rv && pend_rsp) ? 64'(pend_q[0].data) : 64'(0));
    check("spurious", 64'(bus.spurious_o), 64'(mdl_spur));
    last_gnt    = bus.gnt_o;
    last_memreq = bus.mem_req_o;
    last_addr   = bus.mem_addr_o;
    last_spur   = bus.spurious_o;
    if (rv) begin
      if (pend_rsp) void'(pend_q.pop_front());
      else mdl_spur = 1'b1;
    end
    mdl_gnt_vec = '0;
    if (hs) begin
      if (fixed_q.size() > 0) r = fixed_q.pop_front();
      else begin
        r.data = $urandom;
        r.err  = 1'($urandom_range(0, 1));
      end
      r.mgr = sel;
      pend_q.push_back(r);
      exp_q.push_back(r);
      mdl_last = sel;
      mdl_lock = -1;
      mdl_gnt_vec[ss] = 1'b1;
    end else if (mreq) begin
      mdl_lock = sel;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_i        = '1;
    bus.mem_gnt_i    = 1'b1;
    bus.mem_rvalid_i = 1'b1;
    #2;
    check("rst_gnt", 64'(bus.gnt_o), 64'(0));
    check("rst_mem_req", 64'(bus.mem_req_o), 64'(0));
    check("rst_rvalid", 64'(bus.rvalid_o), 64'(0));
    check("rst_spurious", 64'(bus.spurious_o), 64'(0));
    clear_model();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drain();
    req_v = '0;
    rv_en = 1'b1;
    spur_en = 1'b0;
    for (int n = 0; n < 40 && pend_q.size() > 0; n++) cycle();
  endtask

  // Response monitor: pops the scoreboard whenever the arbiter routes a response.
  initial begin
    rsp_t r;
    forever begin
      @(negedge clk);
      #3;
      if (!rst && bus.rvalid_o != '0) begin
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", 64'(bus.rvalid_o), 64'(0));
        end else begin
          r = exp_q.pop_front();
          check("rsp_rvalid", 64'(bus.rvalid_o), 64'(1) << r.mgr);
          check("rsp_err", 64'(bus.err_o), r.err ? 64'(1) << r.mgr : 64'(0));
          check("rsp_rdata", 64'(bus.rdata_o), 64'(r.data));
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    req_v = '0; we_v = '0; gnt_v = 1'b0; rv_en = 1'b0; spur_en = 1'b0;
    for (int i = 0; i < NumReq; i++) begin
      addr_v[i]  = 32'h1000 * (i + 1);
      wdata_v[i] = $urandom;
      be_v[i]    = 4'hF;
    end
    bus.we_i = '0; bus.be_i = '0; bus.addr_i = '0; bus.wdata_i = '0;
    bus.mem_rdata_i = '0; bus.mem_err_i = 1'b0;
    clear_model();
    @(negedge clk);
    do_reset();

    // single manager
    fixed_q.push_back('{0, 32'hCAFE0001, 1'b0});
    req_v = 3'b010; gnt_v = 1'b1;
    cycle();
    check("t1_gnt", 64'(last_gnt), 64'(3'b010));
    req_v = '0; rv_en = 1'b1;
    cycle();

    // round-robin with all requesting
    do_reset();
    req_v = 3'b111; gnt_v = 1'b1; rv_en = 1'b1;
    for (int n = 0; n < 6; n++) begin
      cycle();
      check("t2_rr", 64'(last_gnt), 64'(1) << (n % 3));
    end

    // address-phase lock
    req_v = 3'b001; gnt_v = 1'b0;
    cycle();
    req_v = 3'b101;
    cycle();
    cycle();
    check("t3_lock_addr", 64'(last_addr), 64'(addr_v[0]));
    gnt_v = 1'b1;
    cycle();
    check("t3_gnt0", 64'(last_gnt), 64'(3'b001));
    req_v = 3'b100;
    cycle();
    check("t3_gnt2", 64'(last_gnt), 64'(3'b100));
    drain();

    // FIFO full
    do_reset();
    req_v = 3'b001; gnt_v = 1'b1; rv_en = 1'b0;
    for (int n = 0; n < 4; n++) cycle();
    cycle();
    check("t4_full", 64'(last_memreq), 64'(0));
    rv_en = 1'b1;
    cycle();
    check("t4_pop_same", 64'(last_memreq), 64'(0));
    rv_en = 1'b0;
    cycle();
    check("t4_resume", 64'(last_memreq), 64'(1));
    drain();

    // response ordering
    do_reset();
    fixed_q.push_back('{0, 32'hA, 1'b0});
    fixed_q.push_back('{0, 32'hB, 1'b1});
    fixed_q.push_back('{0, 32'hC, 1'b0});
    gnt_v = 1'b1; rv_en = 1'b0;
    req_v = 3'b100; cycle();
    req_v = 3'b001; cycle();
    req_v = 3'b010; cycle();
    drain();

    // spurious response and reset with outstanding transactions
    req_v = '0; rv_en = 1'b1; spur_en = 1'b1;
    cycle();
    spur_en = 1'b0;
    cycle();
    check("t6_spurious", 64'(last_spur), 64'(1));
    req_v = 3'b001; gnt_v = 1'b1; rv_en = 1'b0;
    cycle(); cycle();
    do_reset();
    req_v = '0; rv_en = 1'b1; spur_en = 1'b1;
    cycle();
    spur_en = 1'b0;
    cycle();

    // randomized traffic
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      gnt_v = ($urandom_range(0, 3) != 0);
      rv_en = ($urandom_range(0, 2) != 0);
      for (int i = 0; i < NumReq; i++) begin
        if (!(req_v[i] && !mdl_gnt_vec[i])) begin
          req_v[i]   = 1'($urandom_range(0, 1));
          we_v[i]    = 1'($urandom_range(0, 1));
          addr_v[i]  = $urandom;
          wdata_v[i] = $urandom;
          be_v[i]    = 4'($urandom);
        end
      end
      cycle();
    end
    drain();
    req_v = '0; rv_en = 1'b0;
    cycle();
    check("drain_pending", 64'(pend_q.size()), 64'(0));
    check("drain_scoreboard", 64'(exp_q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
